// File: rtl/mips_multicycle_core_if.sv
// mips_multicycle_core_if: word-wide memory request/acknowledge bus
interface mips_multicycle_core_if #(parameter int ADDR_W = 8);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;
  modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ack);
  modport slave (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core: multicycle MIPS subset core with a single shared memory port
module mips_multicycle_core #(
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                          clk,
  input  logic                          rst,
  mips_multicycle_core_if.master        bus,
  output logic [31:0]                   pc,
  output logic [2:0]                    state,
  output logic                          retire,
  output logic                          halted,
  input  logic [4:0]                    dbg_raddr,
  output logic [31:0]                   dbg_rdata
);
  typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, HALT = 3'd5} state_t;
  localparam logic [5:0] OP_R = 6'h00, OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B, OP_BEQ = 6'h04, OP_J = 6'h02;
  state_t st, nxt;
  logic [31:0] ir, a, b, alu_out, mdr, alu, imm_s, rs_val, rt_val, wd;
  logic [31:0] rf [32];
  logic [5:0] op, fn;
  logic [4:0] wa;
  logic is_r, legal, ack, done, idle;
  assign op = ir[31:26];
  assign fn = ir[5:0];
  assign is_r = op == OP_R;
  assign imm_s = {{16{ir[15]}}, ir[15:0]};
  assign legal = is_r ? (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A)
                      : (op == OP_ADDI || op == OP_LW || op == OP_SW || op == OP_BEQ || op == OP_J);
  assign alu = !is_r ? a + imm_s :
               fn == 6'h22 ? a - b :
               fn == 6'h24 ? a & b :
               fn == 6'h25 ? a | b :
               fn == 6'h2A ? {31'd0, $signed(a) < $signed(b)} : a + b;
  assign rs_val = ir[25:21] == 5'd0 ? 32'd0 : rf[ir[25:21]];
  assign rt_val = ir[20:16] == 5'd0 ? 32'd0 : rf[ir[20:16]];
  assign dbg_rdata = dbg_raddr == 5'd0 ? 32'd0 : rf[dbg_raddr];
  assign wa = is_r ? ir[15:11] : ir[20:16];
  assign wd = op == OP_LW ? mdr : alu_out;
  // idle forces one non-request cycle after every accepted transaction
  assign bus.mem_req = !rst && !idle && (st == FETCH || st == MEM);
  assign bus.mem_we = st == MEM && op == OP_SW;
  assign bus.mem_addr = st == MEM ? alu_out[ADDR_W-1:0] : pc[ADDR_W-1:0];
  assign bus.mem_wdata = b;
  assign ack = bus.mem_req && bus.mem_ack;
  assign state = st;
  assign halted = st == HALT;
  // next-state and instruction-completion decode
  always_comb begin
    nxt = st;
    done = 1'b0;
    case (st)
      FETCH:  nxt = ack ? DECODE : FETCH;
      DECODE: nxt = legal ? EXEC : HALT;
      EXEC: begin
        nxt = (op == OP_J || op == OP_BEQ) ? FETCH :
              (op == OP_LW || op == OP_SW) ? (alu[1:0] != 2'd0 ? HALT : MEM) : WB;
        done = op == OP_J || op == OP_BEQ;
      end
      MEM: begin
        nxt = !ack ? MEM : op == OP_SW ? FETCH : WB;
        done = ack && op == OP_SW;
      end
      WB: begin
        nxt = FETCH;
        done = 1'b1;
      end
      default: nxt = HALT;
    endcase
  end
  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= FETCH;
    else st <= nxt;
  end
  // datapath registers, retire pulse and bus gap flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
      ir <= '0;
      a <= '0;
      b <= '0;
      alu_out <= '0;
      mdr <= '0;
      retire <= 1'b0;
      idle <= 1'b0;
    end else begin
      retire <= done;
      idle <= ack;
      if (st == FETCH && ack) begin
        ir <= bus.mem_rdata;
        pc <= pc + 32'd4;
      end
      if (st == DECODE) begin
        a <= rs_val;
        b <= rt_val;
      end
      if (st == EXEC) alu_out <= alu;
      if (st == EXEC && op == OP_BEQ && a == b) pc <= pc + (imm_s << 2);
      if (st == EXEC && op == OP_J) pc <= {pc[31:28], ir[25:0], 2'b00};
      if (st == MEM && ack) mdr <= bus.mem_rdata;
    end
  end
  // register file write-back; register 0 is never written
  always_ff @(posedge clk) begin
    if (st == WB && wa != 5'd0) rf[wa] <= wd;
  end
endmodule
